// File: rtl/ctrl_pkg.sv
// Shared encodings and the registered control bundle for the decode stage.
package ctrl_pkg;

  typedef enum logic [2:0] {
    RES_ALU   = 3'b000,
    RES_MEM   = 3'b001,
    RES_PC4   = 3'b010,
    RES_IMM   = 3'b011,
    RES_PCIMM = 3'b100
  } result_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } branch_type_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10
  } jump_type_e;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0]  pc;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    result_src_e  result_src;
    alu_ctrl_e    alu_ctrl;
    logic         alu_src;
    logic         reg_write;
    logic         mem_write;
    imm_src_e     imm_src;
    mem_size_e    mem_size;
    logic         mem_unsigned;
    branch_type_e branch_type;
    jump_type_e   jump_type;
    logic         illegal;
  } ctrl_bundle_t;

  // alt selects sub/sra over add/srl (funct7[5] for R-type, shift-right-immediate only for I-type)
  function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decode into a control bundle; anything not
// decodable (or outside the base subset when FULL_RV32I=0) becomes an all-zero bundle with illegal set.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter bit FULL_RV32I = 1'b1
) (
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  output ctrl_bundle_t bundle
);

  logic [6:0]   opcode_s;
  logic [2:0]   funct3_s;
  logic [6:0]   funct7_s;
  logic         legal_s;
  logic         base_s;
  ctrl_bundle_t dec_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  // Opcode/funct decode; base_s marks members of the reduced instruction subset.
  always_comb begin
    dec_s   = '0;
    legal_s = 1'b0;
    base_s  = 1'b0;
    case (opcode_s)
      OP_LUI: begin
        legal_s = 1'b1; base_s = 1'b1;
        dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_U; dec_s.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        legal_s = 1'b1;
        dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_U; dec_s.result_src = RES_PCIMM;
      end
      OP_JAL: begin
        legal_s = 1'b1; base_s = 1'b1;
        dec_s.reg_write = 1'b1; dec_s.imm_src = IMM_J;
        dec_s.result_src = RES_PC4; dec_s.jump_type = JMP_JAL;
      end
      OP_JALR: begin
        legal_s = (funct3_s == 3'b000); base_s = 1'b1;
        dec_s.reg_write = 1'b1; dec_s.alu_src = 1'b1; dec_s.imm_src = IMM_I;
        dec_s.result_src = RES_PC4; dec_s.jump_type = JMP_JALR;
      end
      OP_BRANCH: begin
        legal_s = 1'b1;
        dec_s.imm_src = IMM_B;
        case (funct3_s)
          3'b000:  begin dec_s.branch_type = BR_BEQ;  dec_s.alu_ctrl = ALU_SUB; base_s = 1'b1; end
          3'b001:  begin dec_s.branch_type = BR_BNE;  dec_s.alu_ctrl = ALU_SUB; base_s = 1'b1; end
          3'b100:  begin dec_s.branch_type = BR_BLT;  dec_s.alu_ctrl = ALU_SLT; end
          3'b101:  begin dec_s.branch_type = BR_BGE;  dec_s.alu_ctrl = ALU_SLT; end
          3'b110:  begin dec_s.branch_type = BR_BLTU; dec_s.alu_ctrl = ALU_SLTU; end
          3'b111:  begin dec_s.branch_type = BR_BGEU; dec_s.alu_ctrl = ALU_SLTU; end
          default: legal_s = 1'b0;
        endcase
      end
      OP_LOAD: begin
        case (funct3_s)
          3'b000, 3'b001, 3'b010, 3'b101: legal_s = 1'b1;
          3'b100:  begin legal_s = 1'b1; base_s = 1'b1; end
          default: legal_s = 1'b0;
        endcase
        dec_s.reg_write = 1'b1; dec_s.alu_src = 1'b1; dec_s.imm_src = IMM_I;
        dec_s.result_src = RES_MEM;
        dec_s.mem_size = mem_size_e'(funct3_s[1:0]);
        dec_s.mem_unsigned = funct3_s[2];
      end
      OP_STORE: begin
        case (funct3_s)
          3'b000:  begin legal_s = 1'b1; base_s = 1'b1; end
          3'b001, 3'b010: legal_s = 1'b1;
          default: legal_s = 1'b0;
        endcase
        dec_s.mem_write = 1'b1; dec_s.alu_src = 1'b1; dec_s.imm_src = IMM_S;
        dec_s.mem_size = mem_size_e'(funct3_s[1:0]);
      end
      OP_IMM: begin
        case (funct3_s)
          3'b001:  legal_s = (funct7_s == 7'b0000000);
          3'b101:  legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
          default: legal_s = 1'b1;
        endcase
        base_s = (funct3_s == 3'b000);
        dec_s.reg_write = 1'b1; dec_s.alu_src = 1'b1; dec_s.imm_src = IMM_I;
        dec_s.alu_ctrl = alu_from_funct(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
      end
      OP_REG: begin
        legal_s = (funct7_s == 7'b0000000) ||
                  ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
        base_s  = (funct3_s == 3'b000) || (funct3_s == 3'b100) || (funct3_s == 3'b111);
        dec_s.reg_write = 1'b1;
        dec_s.alu_ctrl = alu_from_funct(funct3_s, funct7_s[5]);
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Squash the decoded controls for illegal words; register fields are always plain copies.
  always_comb begin
    if (legal_s && (FULL_RV32I || base_s)) begin
      bundle = dec_s;
    end else begin
      bundle = '0;
      bundle.illegal = 1'b1;
    end
    bundle.pc  = pc;
    bundle.rd  = instr[11:7];
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
  end

endmodule

// File: rtl/control_decode_stage.sv
// Decode pipeline stage: one-entry registered output with valid/ready
// handshake, flush, and a saturating illegal-instruction counter.
module control_decode_stage
  import ctrl_pkg::*;
#(
  parameter bit          FULL_RV32I = 1'b1,
  parameter int unsigned ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [31:0]          pc_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          pc_out,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [2:0]           result_src,
  output logic [3:0]           alu_ctrl,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic [2:0]           imm_src,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  output logic [2:0]           branch_type,
  output logic [1:0]           jump_type,
  output logic                 illegal,
  output logic                 ill_sticky,
  input  logic                 clr_ill,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_bundle_t         dec_s;
  ctrl_bundle_t         bundle_r;
  logic                 out_valid_r;
  logic                 accept_s;
  logic                 ill_sticky_r;
  logic [ILL_CNT_W-1:0] ill_count_r;

  instr_decoder #(.FULL_RV32I(FULL_RV32I)) u_decoder (
    .instr  (instr),
    .pc     (pc_in),
    .bundle (dec_s)
  );

  assign in_ready = (!out_valid_r || out_ready) && !flush;
  assign accept_s = in_valid && in_ready;

  // Output register: flush kills the entry, accept loads it, a consumed entry retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      bundle_r    <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      bundle_r    <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      bundle_r    <= dec_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Illegal tracking: only accepted words count, so flushed ones never reach here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_sticky_r <= 1'b0;
      ill_count_r  <= '0;
    end else if (clr_ill) begin
      ill_sticky_r <= 1'b0;
      ill_count_r  <= '0;
    end else if (accept_s && dec_s.illegal) begin
      ill_sticky_r <= 1'b1;
      if (ill_count_r != {ILL_CNT_W{1'b1}}) begin
        ill_count_r <= ill_count_r + ILL_CNT_W'(1);
      end else begin
        ill_count_r <= ill_count_r;
      end
    end else begin
      ill_sticky_r <= ill_sticky_r;
    end
  end

  assign out_valid    = out_valid_r;
  assign pc_out       = bundle_r.pc;
  assign rd           = bundle_r.rd;
  assign rs1          = bundle_r.rs1;
  assign rs2          = bundle_r.rs2;
  assign result_src   = bundle_r.result_src;
  assign alu_ctrl     = bundle_r.alu_ctrl;
  assign alu_src      = bundle_r.alu_src;
  assign reg_write    = bundle_r.reg_write;
  assign mem_write    = bundle_r.mem_write;
  assign imm_src      = bundle_r.imm_src;
  assign mem_size     = bundle_r.mem_size;
  assign mem_unsigned = bundle_r.mem_unsigned;
  assign branch_type  = bundle_r.branch_type;
  assign jump_type    = bundle_r.jump_type;
  assign illegal      = bundle_r.illegal;
  assign ill_sticky   = ill_sticky_r;
  assign ill_count    = ill_count_r;

endmodule

// File: tb/tb_control_decode_stage.sv
// Drives a full-ISA instance and a base-subset / 2-bit-counter instance in
// lockstep, checking both against a mask/match instruction table model.
module tb_control_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, flush, out_ready, clr_ill;
  logic [31:0] instr, pc_in;

  logic f_in_ready, f_out_valid, f_alu_src, f_reg_write, f_mem_write, f_mem_unsigned, f_illegal, f_ill_sticky;
  logic [31:0] f_pc_out;
  logic [4:0] f_rd, f_rs1, f_rs2;
  logic [2:0] f_result_src, f_imm_src, f_branch_type;
  logic [3:0] f_alu_ctrl;
  logic [1:0] f_mem_size, f_jump_type;
  logic [7:0] f_ill_count;

  logic b_in_ready, b_out_valid, b_alu_src, b_reg_write, b_mem_write, b_mem_unsigned, b_illegal, b_ill_sticky;
  logic [31:0] b_pc_out;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [2:0] b_result_src, b_imm_src, b_branch_type;
  logic [3:0] b_alu_ctrl;
  logic [1:0] b_mem_size, b_jump_type;
  logic [1:0] b_ill_count;

  control_decode_stage dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready), .instr(instr), .pc_in(pc_in),
    .flush(flush), .out_valid(f_out_valid), .out_ready(out_ready), .pc_out(f_pc_out), .rd(f_rd),
    .rs1(f_rs1), .rs2(f_rs2), .result_src(f_result_src), .alu_ctrl(f_alu_ctrl), .alu_src(f_alu_src),
    .reg_write(f_reg_write), .mem_write(f_mem_write), .imm_src(f_imm_src), .mem_size(f_mem_size),
    .mem_unsigned(f_mem_unsigned), .branch_type(f_branch_type), .jump_type(f_jump_type),
    .illegal(f_illegal), .ill_sticky(f_ill_sticky), .clr_ill(clr_ill), .ill_count(f_ill_count));

  control_decode_stage #(.FULL_RV32I(1'b0), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr), .pc_in(pc_in),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .pc_out(b_pc_out), .rd(b_rd),
    .rs1(b_rs1), .rs2(b_rs2), .result_src(b_result_src), .alu_ctrl(b_alu_ctrl), .alu_src(b_alu_src),
    .reg_write(b_reg_write), .mem_write(b_mem_write), .imm_src(b_imm_src), .mem_size(b_mem_size),
    .mem_unsigned(b_mem_unsigned), .branch_type(b_branch_type), .jump_type(b_jump_type),
    .illegal(b_illegal), .ill_sticky(b_ill_sticky), .clr_ill(clr_ill), .ill_count(b_ill_count));

  wire [21:0] f_ctrl = {f_result_src, f_alu_ctrl, f_alu_src, f_reg_write, f_mem_write, f_imm_src,
                        f_mem_size, f_mem_unsigned, f_branch_type, f_jump_type, f_illegal};
  wire [21:0] b_ctrl = {b_result_src, b_alu_ctrl, b_alu_src, b_reg_write, b_mem_write, b_imm_src,
                        b_mem_size, b_mem_unsigned, b_branch_type, b_jump_type, b_illegal};

  typedef struct {
    bit [31:0] mask;
    bit [31:0] match;
    bit        base;
    bit [2:0]  rs;
    bit [3:0]  alu;
    bit        asrc, rw, mw;
    bit [2:0]  imm;
    bit [1:0]  msz;
    bit        mu;
    bit [2:0]  br;
    bit [1:0]  jmp;
  } ent_t;
  ent_t tbl[$];

  int pass_cnt = 0;
  int total = 0;

  bit        m_valid;
  bit [31:0] m_pc;
  bit [14:0] m_regs;
  bit [21:0] m_ctrl_f, m_ctrl_b;
  int        m_cnt_f, m_cnt_b;
  bit        m_st_f, m_st_b;

  task automatic ent(input bit [31:0] mask, match, input bit base, input bit [2:0] rs, input bit [3:0] alu,
                     input bit asrc, rw, mw, input bit [2:0] imm, input bit [1:0] msz, input bit mu,
                     input bit [2:0] br, input bit [1:0] jmp);
    ent_t e;
    e.mask = mask; e.match = match; e.base = base; e.rs = rs; e.alu = alu; e.asrc = asrc; e.rw = rw;
    e.mw = mw; e.imm = imm; e.msz = msz; e.mu = mu; e.br = br; e.jmp = jmp;
    tbl.push_back(e);
  endtask

  function automatic bit [21:0] ref_ctrl(input bit [31:0] ins, input bit full);
    foreach (tbl[i]) begin
      if (((ins & tbl[i].mask) == tbl[i].match) && (full || tbl[i].base))
        return {tbl[i].rs, tbl[i].alu, tbl[i].asrc, tbl[i].rw, tbl[i].mw, tbl[i].imm,
                tbl[i].msz, tbl[i].mu, tbl[i].br, tbl[i].jmp, 1'b0};
    end
    return 22'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input bit r, iv, fl, ordy, clr, input logic [31:0] ins, input logic [31:0] p);
    bit rdy, acc;
    bit [21:0] cf, cb;
    @(negedge clk);
    rst_n = r; in_valid = iv; flush = fl; out_ready = ordy; clr_ill = clr; instr = ins; pc_in = p;
    #1;
    rdy = (!m_valid || ordy) && !fl;
    check("f_in_ready", 64'(f_in_ready), 64'(rdy));
    check("b_in_ready", 64'(b_in_ready), 64'(rdy));
    acc = iv && rdy;
    cf = ref_ctrl(ins, 1'b1);
    cb = ref_ctrl(ins, 1'b0);
    @(posedge clk);
    #1;
    if (!r) begin
      m_valid = 1'b0; m_pc = '0; m_regs = '0; m_ctrl_f = '0; m_ctrl_b = '0;
      m_cnt_f = 0; m_cnt_b = 0; m_st_f = 1'b0; m_st_b = 1'b0;
    end else begin
      if (fl) begin
        m_valid = 1'b0; m_pc = '0; m_regs = '0; m_ctrl_f = '0; m_ctrl_b = '0;
      end else if (acc) begin
        m_valid = 1'b1; m_pc = p; m_regs = {ins[11:7], ins[19:15], ins[24:20]};
        m_ctrl_f = cf; m_ctrl_b = cb;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (clr) begin
        m_cnt_f = 0; m_cnt_b = 0; m_st_f = 1'b0; m_st_b = 1'b0;
      end else if (acc) begin
        if (cf[0]) begin m_st_f = 1'b1; m_cnt_f = (m_cnt_f < 255) ? m_cnt_f + 1 : 255; end
        if (cb[0]) begin m_st_b = 1'b1; m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3; end
      end
    end
    check("f_out_valid", 64'(f_out_valid), 64'(m_valid));
    check("b_out_valid", 64'(b_out_valid), 64'(m_valid));
    check("f_pc_out", 64'(f_pc_out), 64'(m_pc));
    check("b_pc_out", 64'(b_pc_out), 64'(m_pc));
    check("f_regs", 64'({f_rd, f_rs1, f_rs2}), 64'(m_regs));
    check("b_regs", 64'({b_rd, b_rs1, b_rs2}), 64'(m_regs));
    check("f_ctrl", 64'(f_ctrl), 64'(m_ctrl_f));
    check("b_ctrl", 64'(b_ctrl), 64'(m_ctrl_b));
    check("f_ill_count", 64'(f_ill_count), 64'(m_cnt_f));
    check("b_ill_count", 64'(b_ill_count), 64'(m_cnt_b));
    check("f_ill_sticky", 64'(f_ill_sticky), 64'(m_st_f));
    check("b_ill_sticky", 64'(b_ill_sticky), 64'(m_st_b));
  endtask

  initial begin
    ent_t e;
    logic [31:0] ri;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_ill = 1'b0; instr = '0; pc_in = '0;
    m_valid = 1'b0; m_pc = '0; m_regs = '0; m_ctrl_f = '0; m_ctrl_b = '0;
    m_cnt_f = 0; m_cnt_b = 0; m_st_f = 1'b0; m_st_b = 1'b0;

    //   mask          match         base rs   alu  as rw mw imm  msz mu  br   jmp
    ent(32'h0000007F, 32'h00000037, 1, 3'd3, 4'd0, 0, 1, 0, 3'd4, 2'd0, 0, 3'd0, 2'd0); // lui
    ent(32'h0000007F, 32'h00000017, 0, 3'd4, 4'd0, 0, 1, 0, 3'd4, 2'd0, 0, 3'd0, 2'd0); // auipc
    ent(32'h0000007F, 32'h0000006F, 1, 3'd2, 4'd0, 0, 1, 0, 3'd3, 2'd0, 0, 3'd0, 2'd1); // jal
    ent(32'h0000707F, 32'h00000067, 1, 3'd2, 4'd0, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd2); // jalr
    ent(32'h0000707F, 32'h00000063, 1, 3'd0, 4'd1, 0, 0, 0, 3'd2, 2'd0, 0, 3'd1, 2'd0); // beq
    ent(32'h0000707F, 32'h00001063, 1, 3'd0, 4'd1, 0, 0, 0, 3'd2, 2'd0, 0, 3'd2, 2'd0); // bne
    ent(32'h0000707F, 32'h00004063, 0, 3'd0, 4'd8, 0, 0, 0, 3'd2, 2'd0, 0, 3'd3, 2'd0); // blt
    ent(32'h0000707F, 32'h00005063, 0, 3'd0, 4'd8, 0, 0, 0, 3'd2, 2'd0, 0, 3'd4, 2'd0); // bge
    ent(32'h0000707F, 32'h00006063, 0, 3'd0, 4'd9, 0, 0, 0, 3'd2, 2'd0, 0, 3'd5, 2'd0); // bltu
    ent(32'h0000707F, 32'h00007063, 0, 3'd0, 4'd9, 0, 0, 0, 3'd2, 2'd0, 0, 3'd6, 2'd0); // bgeu
    ent(32'h0000707F, 32'h00000003, 0, 3'd1, 4'd0, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // lb
    ent(32'h0000707F, 32'h00001003, 0, 3'd1, 4'd0, 1, 1, 0, 3'd0, 2'd1, 0, 3'd0, 2'd0); // lh
    ent(32'h0000707F, 32'h00002003, 0, 3'd1, 4'd0, 1, 1, 0, 3'd0, 2'd2, 0, 3'd0, 2'd0); // lw
    ent(32'h0000707F, 32'h00004003, 1, 3'd1, 4'd0, 1, 1, 0, 3'd0, 2'd0, 1, 3'd0, 2'd0); // lbu
    ent(32'h0000707F, 32'h00005003, 0, 3'd1, 4'd0, 1, 1, 0, 3'd0, 2'd1, 1, 3'd0, 2'd0); // lhu
    ent(32'h0000707F, 32'h00000023, 1, 3'd0, 4'd0, 1, 0, 1, 3'd1, 2'd0, 0, 3'd0, 2'd0); // sb
    ent(32'h0000707F, 32'h00001023, 0, 3'd0, 4'd0, 1, 0, 1, 3'd1, 2'd1, 0, 3'd0, 2'd0); // sh
    ent(32'h0000707F, 32'h00002023, 0, 3'd0, 4'd0, 1, 0, 1, 3'd1, 2'd2, 0, 3'd0, 2'd0); // sw
    ent(32'h0000707F, 32'h00000013, 1, 3'd0, 4'd0, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // addi
    ent(32'h0000707F, 32'h00002013, 0, 3'd0, 4'd8, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // slti
    ent(32'h0000707F, 32'h00003013, 0, 3'd0, 4'd9, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // sltiu
    ent(32'h0000707F, 32'h00004013, 0, 3'd0, 4'd4, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // xori
    ent(32'h0000707F, 32'h00006013, 0, 3'd0, 4'd3, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // ori
    ent(32'h0000707F, 32'h00007013, 0, 3'd0, 4'd2, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // andi
    ent(32'hFE00707F, 32'h00001013, 0, 3'd0, 4'd5, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // slli
    ent(32'hFE00707F, 32'h00005013, 0, 3'd0, 4'd6, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // srli
    ent(32'hFE00707F, 32'h40005013, 0, 3'd0, 4'd7, 1, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // srai
    ent(32'hFE00707F, 32'h00000033, 1, 3'd0, 4'd0, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // add
    ent(32'hFE00707F, 32'h40000033, 1, 3'd0, 4'd1, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // sub
    ent(32'hFE00707F, 32'h00001033, 0, 3'd0, 4'd5, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // sll
    ent(32'hFE00707F, 32'h00002033, 0, 3'd0, 4'd8, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // slt
    ent(32'hFE00707F, 32'h00003033, 0, 3'd0, 4'd9, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // sltu
    ent(32'hFE00707F, 32'h00004033, 1, 3'd0, 4'd4, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // xor
    ent(32'hFE00707F, 32'h00005033, 0, 3'd0, 4'd6, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // srl
    ent(32'hFE00707F, 32'h40005033, 0, 3'd0, 4'd7, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // sra
    ent(32'hFE00707F, 32'h00006033, 0, 3'd0, 4'd3, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // or
    ent(32'hFE00707F, 32'h00007033, 1, 3'd0, 4'd2, 0, 1, 0, 3'd0, 2'd0, 0, 3'd0, 2'd0); // and

    // reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h0);
    check("rst_out_valid", 64'(f_out_valid), 64'd0);
    check("rst_ill_count", 64'(f_ill_count), 64'd0);

    // add x3,x1,x2
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h100);
    check("add_valid", 64'(f_out_valid), 64'd1);
    check("add_alu_ctrl", 64'(f_alu_ctrl), 64'd0);
    check("add_reg_write", 64'(f_reg_write), 64'd1);
    check("add_rd", 64'(f_rd), 64'd3);

    // beq, then stall two cycles with a new word waiting
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00208463, 32'h104);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h002081B3, 32'h108);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h002081B3, 32'h108);
    check("beq_in_ready", 64'(f_in_ready), 64'd0);
    check("beq_branch_type", 64'(f_branch_type), 64'd1);
    check("beq_imm_src", 64'(f_imm_src), 64'd2);
    check("beq_pc_hold", 64'(f_pc_out), 64'h104);

    // lw outside the base subset
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000A183, 32'h10C);
    check("lw_b_illegal", 64'(b_illegal), 64'd1);
    check("lw_b_reg_write", 64'(b_reg_write), 64'd0);
    check("lw_b_ill_count", 64'(b_ill_count), 64'd1);
    check("lw_b_sticky", 64'(b_ill_sticky), 64'd1);
    check("lw_f_illegal", 64'(f_illegal), 64'd0);

    // five all-ones words saturate the 2-bit counter, then clear
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h110 + 32'(4 * i));
    check("sat_b_ill_count", 64'(b_ill_count), 64'd3);
    check("sat_f_ill_count", 64'(f_ill_count), 64'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    check("clr_b_ill_count", 64'(b_ill_count), 64'd0);
    check("clr_b_sticky", 64'(b_ill_sticky), 64'd0);

    // flush a held bundle while an illegal word is offered
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h002081B3, 32'h200);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h204);
    check("flush_valid", 64'(f_out_valid), 64'd0);
    check("flush_ill_count", 64'(f_ill_count), 64'd0);

    // reset mid-handshake with a counted illegal word held
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h300);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00208463, 32'h304);
    check("rst2_valid", 64'(f_out_valid), 64'd0);
    check("rst2_illegal", 64'(f_illegal), 64'd0);
    check("rst2_b_ill_count", 64'(b_ill_count), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ri = $urandom;
      end else begin
        e = tbl[$urandom_range(0, tbl.size() - 1)];
        ri = e.match | ($urandom & ~e.mask);
      end
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0), ri, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
